// File: rtl/or_fault_tester_pkg.sv
// Shared constants for the gate fault testers: diagnosis codes, bitmap signatures, FSM states.
package or_test_pkg;

   localparam int NUM_VECTORS = 4;

   localparam logic [2:0] DIAG_OK      = 3'd0;
   localparam logic [2:0] DIAG_SA1_ANY = 3'd1;
   localparam logic [2:0] DIAG_B_SA0   = 3'd2;
   localparam logic [2:0] DIAG_A_SA0   = 3'd3;
   localparam logic [2:0] DIAG_Z_SA0   = 3'd4;
   localparam logic [2:0] DIAG_UNKNOWN = 3'd5;

   // Mismatch signatures; bit i corresponds to vector i = {A,B}.
   localparam logic [3:0] BMP_OK      = 4'b0000;
   localparam logic [3:0] BMP_SA1_ANY = 4'b0001;
   localparam logic [3:0] BMP_B_SA0   = 4'b0010;
   localparam logic [3:0] BMP_A_SA0   = 4'b0100;
   localparam logic [3:0] BMP_Z_SA0   = 4'b1110;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_APPLY,
      ST_SAMPLE,
      ST_DIAG,
      ST_FIN
   } state_t;

endpackage

// File: rtl/or_fault_tester_if.sv
// Tester <-> harness/GUT signal bundle; FAULT_CNT exists only when FAULT_CNT_EN is defined.
interface or_fault_tester_if;

   logic       START;
   logic       Z;
   logic       A;
   logic       B;
   logic       BUSY;
   logic       DONE;
   logic [3:0] MISMATCH;
   logic [2:0] FAULT_CODE;
`ifdef FAULT_CNT_EN
   logic [7:0] FAULT_CNT;

   modport master (output START, Z, input A, B, BUSY, DONE, MISMATCH, FAULT_CODE, FAULT_CNT);
   modport slave  (input START, Z, output A, B, BUSY, DONE, MISMATCH, FAULT_CODE, FAULT_CNT);
`else
   modport master (output START, Z, input A, B, BUSY, DONE, MISMATCH, FAULT_CODE);
   modport slave  (input START, Z, output A, B, BUSY, DONE, MISMATCH, FAULT_CODE);
`endif

endinterface

// File: rtl/or_fault_tester_diag.sv
// Combinational stuck-at diagnosis: exact match of the 4-bit mismatch bitmap to a 3-bit code.
module or_fault_diag
   import or_test_pkg::*;
(
   input  logic [3:0] i_bitmap,
   output logic [2:0] o_code
);

   always_comb begin
      o_code = DIAG_UNKNOWN;
      case (i_bitmap)
         BMP_OK:      o_code = DIAG_OK;
         BMP_SA1_ANY: o_code = DIAG_SA1_ANY;
         BMP_B_SA0:   o_code = DIAG_B_SA0;
         BMP_A_SA0:   o_code = DIAG_A_SA0;
         BMP_Z_SA0:   o_code = DIAG_Z_SA0;
         default:     o_code = DIAG_UNKNOWN;
      endcase
   end

endmodule

// File: rtl/or_fault_tester.sv
// Exhaustive stuck-at tester for a two-input OR gate: 4 vectors, SETTLE_CYCLES+1 cycles each.
// Optional macro FAULT_CNT_EN adds a saturating count of faulty runs on FAULT_CNT.
module or_fault_tester #(
   parameter int SETTLE_CYCLES = 4
) (
   input  logic             CLK,
   input  logic             RST,
   or_fault_tester_if.slave bus
);
   import or_test_pkg::*;

   localparam logic [7:0] CNT_RELOAD = 8'(SETTLE_CYCLES - 1);
   localparam logic [1:0] VEC_LAST   = 2'(NUM_VECTORS - 1);

   state_t     r_state, w_state_nxt;
   logic [1:0] r_vec, w_vec_nxt, w_vec_inc;
   logic [7:0] r_cnt, w_cnt_nxt;
   logic       r_a, w_a_nxt;
   logic       r_b, w_b_nxt;
   logic       r_busy, w_busy_nxt;
   logic       r_done, w_done_nxt;
   logic [3:0] r_mis, w_mis_nxt;
   logic [2:0] r_code, w_code_nxt;
   logic [2:0] w_diag_code;

   assign w_vec_inc = r_vec + 2'd1;

   or_fault_diag u_diag (
      .i_bitmap (r_mis),
      .o_code   (w_diag_code)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= ST_IDLE;
         r_vec   <= '0;
         r_cnt   <= '0;
         r_a     <= 1'b0;
         r_b     <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_mis   <= '0;
         r_code  <= DIAG_OK;
      end else begin
         r_state <= w_state_nxt;
         r_vec   <= w_vec_nxt;
         r_cnt   <= w_cnt_nxt;
         r_a     <= w_a_nxt;
         r_b     <= w_b_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_mis   <= w_mis_nxt;
         r_code  <= w_code_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_vec_nxt   = r_vec;
      w_cnt_nxt   = r_cnt;
      w_a_nxt     = r_a;
      w_b_nxt     = r_b;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
      w_mis_nxt   = r_mis;
      w_code_nxt  = r_code;
      unique case (r_state)
         ST_IDLE: begin
            w_a_nxt = 1'b0;
            w_b_nxt = 1'b0;
            if (bus.START) begin
               w_state_nxt = ST_APPLY;
               w_vec_nxt   = '0;
               w_cnt_nxt   = CNT_RELOAD;
               w_mis_nxt   = '0;
               w_code_nxt  = DIAG_OK;
               w_busy_nxt  = 1'b1;
            end
         end
         ST_APPLY: begin
            if (r_cnt == 8'd0) w_state_nxt = ST_SAMPLE;
            else               w_cnt_nxt   = r_cnt - 8'd1;
         end
         ST_SAMPLE: begin
            // A/B are registered, so they are exactly the vector the GUT saw.
            w_mis_nxt[r_vec] = bus.Z ^ (r_a | r_b);
            if (r_vec == VEC_LAST) begin
               w_state_nxt = ST_DIAG;
               w_a_nxt     = 1'b0;
               w_b_nxt     = 1'b0;
            end else begin
               w_state_nxt = ST_APPLY;
               w_vec_nxt   = w_vec_inc;
               w_cnt_nxt   = CNT_RELOAD;
               w_a_nxt     = w_vec_inc[1];
               w_b_nxt     = w_vec_inc[0];
            end
         end
         ST_DIAG: begin
            w_state_nxt = ST_FIN;
            w_code_nxt  = w_diag_code;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
         end
         ST_FIN: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign bus.A          = r_a;
   assign bus.B          = r_b;
   assign bus.BUSY       = r_busy;
   assign bus.DONE       = r_done;
   assign bus.MISMATCH   = r_mis;
   assign bus.FAULT_CODE = r_code;

`ifdef FAULT_CNT_EN
   logic [7:0] r_fault_cnt;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_fault_cnt <= '0;
      end else if (r_state == ST_FIN && r_code != DIAG_OK && r_fault_cnt != 8'hFF) begin
         r_fault_cnt <= r_fault_cnt + 8'd1;
      end
   end

   assign bus.FAULT_CNT = r_fault_cnt;
`endif

endmodule
